// File: rtl/sub_cmp_seq_pkg.sv
// Shared types for the multi-cycle subtract/compare unit: FSM encoding and
// parameter sanity helpers used at elaboration.
package sub_cmp_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    function automatic bit chunk_cfg_ok(input int unsigned width, input int unsigned chunk);
        return (chunk != 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

    // Chunk index width; kept at least 1 bit so a single-chunk build still elaborates.
    function automatic int unsigned idx_width(input int unsigned nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/sub_cmp_seq_if.sv
// Operand/result handshake bundle for sub_cmp_seq; master drives operations,
// slave is the compare unit.
interface sub_cmp_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             overflow;
    logic             is_not_equal;
    logic             is_less_than;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, s, cout, overflow, is_not_equal, is_less_than
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, s, cout, overflow, is_not_equal, is_less_than
    );

endinterface

// File: rtl/sub_cmp_seq_chunk.sv
// CHUNK-bit combinational adder slice computing a + ~b + cin; also exposes the
// carry into its top bit so the caller can derive signed overflow.
module sub_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_nb,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_s,
    output logic             o_cout,
    output logic             o_c_msb
);

    logic [CHUNK:0] w_sum;

    assign w_sum   = {1'b0, i_a} + {1'b0, i_nb} + {{CHUNK{1'b0}}, i_cin};
    assign o_s     = w_sum[CHUNK-1:0];
    assign o_cout  = w_sum[CHUNK];
    // Carry into the top bit recovered from the top sum bit and its operands.
    assign o_c_msb = i_a[CHUNK-1] ^ i_nb[CHUNK-1] ^ w_sum[CHUNK-1];

endmodule

// File: rtl/sub_cmp_seq.sv
// Multi-cycle a-b subtract/compare, CHUNK bits per cycle, LSB chunk first.
// Optional SUB_CMP_SAT_EN: saturate s on overflow/borrow.
module sub_cmp_seq
    import sub_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic          clock,
    input  logic          reset,
    sub_cmp_seq_if.slave  bus
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned KW     = idx_width(NCHUNK);
    localparam logic [KW-1:0] LAST_K = KW'(NCHUNK - 1);

    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
        $error("sub_cmp_seq: CHUNK must be nonzero and divide WIDTH");
    end

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_nb;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] w_s_next;
    logic [KW-1:0]    r_k;
    logic             r_signed;
    logic             r_carry;
    logic             r_nz;
    logic             r_cout;
    logic             r_ovf;
    logic             r_ne;
    logic             r_lt;

    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cnb;
    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic             w_c_msb;
    logic             w_accept;
    logic             w_last;
    logic             w_sovf;
    logic             w_ovf;
    logic             w_lt;
    logic             w_nz;
    logic             w_in_ready;
    logic             w_out_valid;

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_last   = (r_state == RUN) && (r_k == LAST_K);

    assign w_ca  = r_a[32'(r_k) * CHUNK +: CHUNK];
    assign w_cnb = r_nb[32'(r_k) * CHUNK +: CHUNK];

    sub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .i_a     (w_ca),
        .i_nb    (w_cnb),
        .i_cin   (r_carry),
        .o_s     (w_sum),
        .o_cout  (w_cout),
        .o_c_msb (w_c_msb)
    );

    // Flags are only meaningful on the last chunk, where the slice sees the MSB.
    assign w_sovf = w_cout ^ w_c_msb;
    assign w_ovf  = r_signed ? w_sovf : ~w_cout;
    assign w_lt   = r_signed ? (w_sum[CHUNK-1] ^ w_sovf) : ~w_cout;
    assign w_nz   = r_nz | (|w_sum);

    always_comb begin
        w_s_next = r_s;
        w_s_next[32'(r_k) * CHUNK +: CHUNK] = w_sum;
`ifdef SUB_CMP_SAT_EN
        // Signed overflow needs opposite operand signs, so a's sign picks the rail.
        if (w_last && w_ovf) begin
            if (!r_signed) begin
                w_s_next = '0;
            end else if (!r_a[WIDTH-1]) begin
                w_s_next = {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                w_s_next = {1'b1, {(WIDTH-1){1'b0}}};
            end
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)    w_next = RUN;
            RUN:     if (r_k == LAST_K)   w_next = DONE;
            DONE:    if (bus.out_ready)   w_next = IDLE;
            default:                      w_next = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE:    w_in_ready  = 1'b1;
            DONE:    w_out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a      <= '0;
            r_nb     <= '0;
            r_s      <= '0;
            r_k      <= '0;
            r_signed <= 1'b0;
            r_carry  <= 1'b0;
            r_nz     <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_ne     <= 1'b0;
            r_lt     <= 1'b0;
        end else if (w_accept) begin
            r_a      <= bus.a;
            r_nb     <= ~bus.b;
            r_signed <= bus.is_signed;
            r_carry  <= 1'b1;
            r_k      <= '0;
            r_nz     <= 1'b0;
        end else if (r_state == RUN) begin
            r_s     <= w_s_next;
            r_carry <= w_cout;
            r_nz    <= w_nz;
            if (w_last) begin
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
                r_ne   <= w_nz;
                r_lt   <= w_lt;
            end else begin
                r_k <= r_k + KW'(1);
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.s            = r_s;
    assign bus.cout         = r_cout;
    assign bus.overflow     = r_ovf;
    assign bus.is_not_equal = r_ne;
    assign bus.is_less_than = r_lt;

endmodule

// File: tb/tb_sub_cmp_seq.sv
// Directed scoreboard bench for sub_cmp_seq (WIDTH=32, CHUNK=8); honours
// SUB_CMP_SAT_EN in its reference model.
module tb_sub_cmp_seq;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    sub_cmp_seq_if #(.WIDTH(32)) bus ();

    sub_cmp_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        ne;
        logic        lt;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sg);
        exp_t        r;
        logic [32:0] d;
        logic        sovf;
        d      = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r.s    = d[31:0];
        r.cout = d[32];
        sovf   = (a[31] != b[31]) && (d[31] != a[31]);
        r.ovf  = sg ? sovf : ~d[32];
        r.ne   = (a != b);
        r.lt   = sg ? ($signed(a) < $signed(b)) : (a < b);
`ifdef SUB_CMP_SAT_EN
        if (r.ovf) begin
            if (!sg)        r.s = 32'h0000_0000;
            else if (a[31]) r.s = 32'h8000_0000;
            else            r.s = 32'h7FFF_FFFF;
        end
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        chk($sformatf("%s.s", tag),    bus.s,                   cur.s);
        chk($sformatf("%s.cout", tag), 32'(bus.cout),           32'(cur.cout));
        chk($sformatf("%s.ovf", tag),  32'(bus.overflow),       32'(cur.ovf));
        chk($sformatf("%s.ne", tag),   32'(bus.is_not_equal),   32'(cur.ne));
        chk($sformatf("%s.lt", tag),   32'(bus.is_less_than),   32'(cur.lt));
    endtask

    // Called #1 after a rising edge; the following edge is the accept edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sg);
        bus.a         = a;
        bus.b         = b;
        bus.is_signed = sg;
        bus.in_valid  = 1'b1;
        chk("in_ready_at_issue", 32'(bus.in_ready), 32'd1);
        q.push_back(model(a, b, sg));
        @(posedge clock);
        #1;
        bus.in_valid  = 1'b0;
        bus.a         = $urandom;
        bus.b         = $urandom;
        bus.is_signed = ~sg;
    endtask

    task automatic wait_result(input string tag);
        int lat;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            lat++;
            if (bus.out_valid) break;
        end
        chk($sformatf("%s.latency", tag), 32'(lat), 32'd4);
        chk($sformatf("%s.out_valid", tag), 32'(bus.out_valid), 32'd1);
        if (q.size() > 0) begin
            cur = q.pop_front();
            check_outputs(tag);
        end else begin
            chk($sformatf("%s.scoreboard_empty", tag), 32'(q.size()), 32'd1);
        end
    endtask

    task automatic release_result(input string tag, input int stall);
        for (int i = 0; i < stall; i++) begin
            @(posedge clock);
            #1;
            chk($sformatf("%s.stall_valid", tag), 32'(bus.out_valid), 32'd1);
            chk($sformatf("%s.stall_ready", tag), 32'(bus.in_ready),  32'd0);
            check_outputs($sformatf("%s.stall%0d", tag, i));
        end
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        chk($sformatf("%s.rel_valid", tag), 32'(bus.out_valid), 32'd0);
        chk($sformatf("%s.rel_ready", tag), 32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.is_signed = 1'b0;
        #12;
        chk("rst.in_ready",  32'(bus.in_ready),     32'd1);
        chk("rst.out_valid", 32'(bus.out_valid),    32'd0);
        chk("rst.s",         bus.s,                 32'd0);
        chk("rst.cout",      32'(bus.cout),         32'd0);
        chk("rst.ovf",       32'(bus.overflow),     32'd0);
        chk("rst.ne",        32'(bus.is_not_equal), 32'd0);
        chk("rst.lt",        32'(bus.is_less_than), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        issue(32'd5, 32'd3, 1'b1);
        wait_result("t1");
        release_result("t1", 0);

        issue(32'h8000_0000, 32'd1, 1'b1);
        wait_result("t2");
        release_result("t2", 0);

        issue(32'd1, 32'd2, 1'b0);
        wait_result("t3");
        release_result("t3", 0);

        issue(32'h1234_5678, 32'h1234_5678, 1'b1);
        wait_result("t4eq");
        release_result("t4eq", 0);

        issue(32'hFFFF_FFFF, 32'd1, 1'b1);
        wait_result("t4s");
        release_result("t4s", 0);

        issue(32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_result("t4u");
        release_result("t4u", 0);

        // Stalled result with a competing offer that must wait for the handshake.
        issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_result("t5");
        bus.a         = 32'd100;
        bus.b         = 32'd40;
        bus.is_signed = 1'b0;
        bus.in_valid  = 1'b1;
        release_result("t5", 5);
        issue(32'd100, 32'd40, 1'b0);
        wait_result("t5next");
        release_result("t5next", 0);

        // Asynchronous reset with chunk index at 2.
        issue(32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("t6.out_valid", 32'(bus.out_valid),    32'd0);
        chk("t6.in_ready",  32'(bus.in_ready),     32'd1);
        chk("t6.s",         bus.s,                 32'd0);
        chk("t6.ne",        32'(bus.is_not_equal), 32'd0);
        void'(q.pop_back());
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("t6.idle_after", 32'(bus.in_ready), 32'd1);
        issue(32'd9, 32'd9, 1'b0);
        wait_result("t6next");
        release_result("t6next", 0);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rs;
            ra = $urandom;
            rb = (i == 2) ? ra : $urandom;
            rs = 1'(i % 2);
            issue(ra, rb, rs);
            wait_result($sformatf("rnd%0d", i));
            release_result($sformatf("rnd%0d", i), i % 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
